// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// holds each instruction until decode accepts it. Optional macro: NPC_JR_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        id_ready,
  input  logic [1:0]  npc_op,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc_inc;
  logic [31:0] br_off;
  logic [31:0] npc;
  logic        fetch_done;
  logic        accept;

  assign fetch_done = (state == S_FETCH) && imem_ack;
  assign accept     = (state == S_VALID) && id_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_done) begin
        instr_q <= imem_rdata;
      end
      if (accept) begin
        pc <= npc;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (imem_ack) state_nxt = S_VALID;
      S_VALID: if (id_ready) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next-PC arithmetic wraps modulo 2^32 by construction of the 32-bit adders.
  assign pc_inc = pc + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

`ifdef NPC_JR_EN
  always_comb begin
    npc = pc_inc;
    unique case (npc_op)
      NPC_PLUS4:  npc = pc_inc;
      NPC_BRANCH: npc = pc_inc + br_off;
      NPC_JUMP:   npc = {pc_inc[31:28], instr_q[25:0], 2'b00};
      NPC_JR:     npc = rs_data;
      default:    npc = pc_inc;
    endcase
  end
`else
  // rs_data has no consumer without jr support; fold it into a named sink.
  logic unused_rs_data;
  assign unused_rs_data = ^rs_data;

  always_comb begin
    npc = pc_inc;
    unique case (npc_op)
      NPC_PLUS4:  npc = pc_inc;
      NPC_BRANCH: npc = pc_inc + br_off;
      NPC_JUMP:   npc = {pc_inc[31:28], instr_q[25:0], 2'b00};
      NPC_JR:     npc = pc_inc;
      default:    npc = pc_inc;
    endcase
  end
`endif

  // pc only moves on accept, so it is both the fetch address and the PC of
  // the held instruction.
  assign imem_req    = (state == S_FETCH);
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_valid = (state == S_VALID);
  assign pc_out      = pc;
  assign pc_plus4    = pc_inc;

endmodule
